// File: rtl/mdu_pkg.sv
// Shared definitions for the M-extension sequencer: operand width, ALU select
// codes for the multiply/divide family and the sequencer state encoding.
package mdu_pkg;

  localparam int XLEN = 32;

  localparam logic [4:0] SEL_MUL    = 5'b01001;
  localparam logic [4:0] SEL_MULH   = 5'b01010;
  localparam logic [4:0] SEL_MULHU  = 5'b01011;
  localparam logic [4:0] SEL_MULHSU = 5'b01100;
  localparam logic [4:0] SEL_DIV    = 5'b01101;
  localparam logic [4:0] SEL_DIVU   = 5'b01110;
  localparam logic [4:0] SEL_REM    = 5'b01111;
  localparam logic [4:0] SEL_REMU   = 5'b10000;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE_S
  } state_t;

  function automatic logic is_mdu_op(input logic [4:0] sel);
    return (sel >= SEL_MUL) && (sel <= SEL_REMU);
  endfunction

  function automatic logic is_div_op(input logic [4:0] sel);
    return (sel >= SEL_DIV) && (sel <= SEL_REMU);
  endfunction

endpackage

// File: rtl/mdu_step.sv
// One iteration of the sequencer datapath over the 64-bit accumulator:
// LSB-first shift-add for multiply, restoring trial subtract for divide.
module mdu_step
  import mdu_pkg::*;
(
  input  logic                is_div,
  input  logic [2*XLEN-1:0]   acc,
  input  logic [XLEN-1:0]     operand,
  output logic [2*XLEN-1:0]   acc_next
);

  logic [XLEN:0]   sum;
  logic [XLEN:0]   partial;
  logic [XLEN-1:0] diff;
  logic            ge;

  // Multiply keeps {hi, multiplier} and shifts right; divide keeps
  // {remainder, dividend/quotient} and shifts left one bit per step.
  always_comb begin
    sum     = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, operand & {XLEN{acc[0]}}};
    partial = acc[2*XLEN-1:XLEN-1];
    ge      = partial[XLEN] || (partial[XLEN-1:0] >= operand);
    diff    = partial[XLEN-1:0] - operand;
    if (is_div) begin
      acc_next = {(ge ? diff : partial[XLEN-1:0]), acc[XLEN-2:0], ge};
    end else begin
      acc_next = {sum, acc[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/mdu_sequencer.sv
// Multi-cycle RV32M multiply/divide sequencer: captures one operation, runs 32
// iterations of mdu_step, applies sign fix-up and pulses done with the result.
module mdu_sequencer
  import mdu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [4:0]       select,
  input  logic [XLEN-1:0]  data1,
  input  logic [XLEN-1:0]  data2,
  input  logic             flush,
  output logic [XLEN-1:0]  result,
  output logic             busy,
  output logic             done
);

  state_t            state;
  logic [4:0]        count;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   operand;
  logic [4:0]        op_sel;
  logic              neg_res;

  logic [2*XLEN-1:0] acc_next;

  logic              in_is_div;
  logic              a_signed;
  logic              b_signed;
  logic              a_neg;
  logic              b_neg;
  logic [XLEN-1:0]   mag_a;
  logic [XLEN-1:0]   mag_b;
  logic              in_neg;
  logic [2*XLEN-1:0] init_acc;
  logic [XLEN-1:0]   init_operand;
  logic              div_zero;
  logic              overflow;
  logic              corner;
  logic [XLEN-1:0]   corner_value;

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quot;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   fix_value;

  mdu_step u_step (
    .is_div   (is_div_op(op_sel)),
    .acc      (acc),
    .operand  (operand),
    .acc_next (acc_next)
  );

  // Operand preparation at capture: magnitudes, result sign and the
  // divide corner cases that bypass the iteration entirely.
  always_comb begin
    in_is_div = is_div_op(select);
    a_signed  = 1'b0;
    b_signed  = 1'b0;
    case (select)
      SEL_MULH:        begin a_signed = 1'b1; b_signed = 1'b1; end
      SEL_MULHSU:      a_signed = 1'b1;
      SEL_DIV, SEL_REM: begin a_signed = 1'b1; b_signed = 1'b1; end
      default:         ;
    endcase
    a_neg  = a_signed & data1[XLEN-1];
    b_neg  = b_signed & data2[XLEN-1];
    mag_a  = a_neg ? (~data1 + 1'b1) : data1;
    mag_b  = b_neg ? (~data2 + 1'b1) : data2;
    in_neg = (select == SEL_REM) ? a_neg : (a_neg ^ b_neg);

    init_acc     = {{XLEN{1'b0}}, (in_is_div ? mag_a : mag_b)};
    init_operand = in_is_div ? mag_b : mag_a;

    div_zero = in_is_div && (data2 == '0);
    overflow = ((select == SEL_DIV) || (select == SEL_REM)) &&
               (data1 == 32'h8000_0000) && (data2 == 32'hFFFF_FFFF);
    corner   = div_zero || overflow;

    corner_value = '0;
    if (div_zero) begin
      corner_value = ((select == SEL_DIV) || (select == SEL_DIVU)) ? '1 : data1;
    end else if (overflow) begin
      corner_value = (select == SEL_DIV) ? 32'h8000_0000 : '0;
    end
  end

  // Sign correction and word select applied to the finished accumulator.
  always_comb begin
    prod = neg_res ? (~acc + 1'b1) : acc;
    quot = neg_res ? (~acc[XLEN-1:0] + 1'b1) : acc[XLEN-1:0];
    rem  = neg_res ? (~acc[2*XLEN-1:XLEN] + 1'b1) : acc[2*XLEN-1:XLEN];
    case (op_sel)
      SEL_MUL:                          fix_value = prod[XLEN-1:0];
      SEL_MULH, SEL_MULHU, SEL_MULHSU:  fix_value = prod[2*XLEN-1:XLEN];
      SEL_DIV, SEL_DIVU:                fix_value = quot;
      SEL_REM, SEL_REMU:                fix_value = rem;
      default:                          fix_value = '0;
    endcase
  end

  // Control FSM; busy and done are registered alongside the state so that
  // busy covers exactly CALC and FIX and done covers exactly DONE_S.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      count   <= '0;
      acc     <= '0;
      operand <= '0;
      op_sel  <= '0;
      neg_res <= 1'b0;
      result  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE_S: begin
          done  <= 1'b0;
          state <= IDLE;
          if (!flush && start && is_mdu_op(select)) begin
            op_sel <= select;
            count  <= '0;
            if (corner) begin
              result <= corner_value;
              done   <= 1'b1;
              state  <= DONE_S;
            end else begin
              acc     <= init_acc;
              operand <= init_operand;
              neg_res <= in_neg;
              busy    <= 1'b1;
              state   <= CALC;
            end
          end
        end
        CALC: begin
          if (flush) begin
            busy  <= 1'b0;
            count <= '0;
            state <= IDLE;
          end else begin
            acc   <= acc_next;
            count <= count + 5'd1;
            if (count == 5'd31) begin
              state <= FIX;
            end
          end
        end
        FIX: begin
          busy <= 1'b0;
          if (flush) begin
            state <= IDLE;
          end else begin
            result <= fix_value;
            done   <= 1'b1;
            state  <= DONE_S;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Self-checking bench for mdu_sequencer: a cycle-level reference model checked
// every cycle, plus directed operations with hand-computed results and timing.
module tb_mdu_sequencer;

  localparam logic [4:0] T_MUL    = 5'b01001;
  localparam logic [4:0] T_MULH   = 5'b01010;
  localparam logic [4:0] T_MULHU  = 5'b01011;
  localparam logic [4:0] T_MULHSU = 5'b01100;
  localparam logic [4:0] T_DIV    = 5'b01101;
  localparam logic [4:0] T_DIVU   = 5'b01110;
  localparam logic [4:0] T_REM    = 5'b01111;
  localparam logic [4:0] T_REMU   = 5'b10000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [4:0]  select = '0;
  logic [31:0] data1 = '0;
  logic [31:0] data2 = '0;
  logic [31:0] result;
  logic        busy;
  logic        done;

  int passed = 0;
  int total = 0;
  bit checking = 1'b0;

  logic        m_busy;
  logic        m_done;
  logic [31:0] m_result;
  logic [31:0] m_pending;
  int          m_remain;

  mdu_sequencer dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .select (select),
    .data1  (data1),
    .data2  (data2),
    .flush  (flush),
    .result (result),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  function automatic logic is_legal(input logic [4:0] sel);
    return (sel >= T_MUL) && (sel <= T_REMU);
  endfunction

  function automatic logic is_corner(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b);
    return ((sel >= T_DIV) && (sel <= T_REMU) && (b == 32'd0)) ||
           (((sel == T_DIV) || (sel == T_REM)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF));
  endfunction

  // Architectural RV32M result computed with plain 64-bit arithmetic.
  function automatic logic [31:0] ref_result(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, p;
    longint unsigned ua, ub, up;
    logic [31:0]     r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    r  = '0;
    case (sel)
      T_MUL:    begin up = ua * ub; r = up[31:0]; end
      T_MULH:   begin p = sa * sb; r = p[63:32]; end
      T_MULHSU: begin p = sa * longint'(ub); r = p[63:32]; end
      T_MULHU:  begin up = ua * ub; r = up[63:32]; end
      T_DIV: begin
        if (b == 32'd0) r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
        else begin p = sa / sb; r = p[31:0]; end
      end
      T_DIVU: begin
        if (b == 32'd0) r = 32'hFFFF_FFFF;
        else begin up = ua / ub; r = up[31:0]; end
      end
      T_REM: begin
        if (b == 32'd0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
        else begin p = sa % sb; r = p[31:0]; end
      end
      T_REMU: begin
        if (b == 32'd0) r = a;
        else begin up = ua % ub; r = up[31:0]; end
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  // Cycle-level expectation: accepted normal ops finish 33 edges later,
  // corner cases finish on the capture edge, flush abandons the op.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy   <= 1'b0;
      m_done   <= 1'b0;
      m_result <= '0;
      m_pending <= '0;
      m_remain <= 0;
    end else if (m_busy) begin
      if (flush) begin
        m_busy   <= 1'b0;
        m_remain <= 0;
      end else if (m_remain == 1) begin
        m_busy   <= 1'b0;
        m_done   <= 1'b1;
        m_result <= m_pending;
        m_remain <= 0;
      end else begin
        m_remain <= m_remain - 1;
      end
    end else begin
      m_done <= 1'b0;
      if (!flush && start && is_legal(select)) begin
        if (is_corner(select, data1, data2)) begin
          m_done   <= 1'b1;
          m_result <= ref_result(select, data1, data2);
        end else begin
          m_busy    <= 1'b1;
          m_remain  <= 33;
          m_pending <= ref_result(select, data1, data2);
        end
      end
    end
  end

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual === expected) begin
      passed++;
    end else begin
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  always @(negedge clk) begin
    if (checking) begin
      check_output("model_busy", {31'd0, busy}, {31'd0, m_busy});
      check_output("model_done", {31'd0, done}, {31'd0, m_done});
      check_output("model_result", result, m_result);
    end
  end

  // Called at a negedge; returns at the negedge right after the capture edge
  // with start dropped and the data inputs scrambled.
  task automatic apply_stimulus(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b);
    start  = 1'b1;
    select = sel;
    data1  = a;
    data2  = b;
    @(posedge clk);
    @(negedge clk);
    start  = 1'b0;
    select = 5'(($urandom % 8) + 9);
    data1  = $urandom;
    data2  = $urandom;
  endtask

  // Waits (bounded) for done, counting edges since capture and busy cycles.
  task automatic wait_done(input string name, input logic [31:0] exp, input int exp_edges, input int first_cyc);
    int cyc;
    int nbusy;
    cyc   = first_cyc;
    nbusy = 0;
    for (int i = 0; i < 60; i++) begin
      if (busy) nbusy++;
      if (done || cyc >= 45) break;
      @(negedge clk);
      cyc++;
    end
    check_output({name, "_result"}, result, exp);
    check_output({name, "_edges"}, cyc, exp_edges);
    if (first_cyc == 0) begin
      check_output({name, "_busy_cycles"}, nbusy, (exp_edges == 0) ? 0 : 33);
    end
  endtask

  task automatic run_op(input string name, input logic [4:0] sel, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_edges);
    apply_stimulus(sel, a, b);
    wait_done(name, exp, exp_edges, 0);
  endtask

  task automatic expect_quiet(input string name, input logic [31:0] held, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      if (done || busy) seen++;
      @(negedge clk);
    end
    check_output({name, "_quiet"}, seen, 0);
    check_output({name, "_held"}, result, held);
  endtask

  initial begin
    check_output("ref_mulhsu", ref_result(T_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFF);
    check_output("ref_rem", ref_result(T_REM, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);

    repeat (2) @(negedge clk);
    check_output("reset_result", result, 32'd0);
    check_output("reset_busy", {31'd0, busy}, 32'd0);
    check_output("reset_done", {31'd0, done}, 32'd0);
    rst = 1'b0;
    checking = 1'b1;
    @(negedge clk);

    // Back-to-back multiplies: second start lands in the DONE_S cycle.
    run_op("mul_7x6", T_MUL, 32'd7, 32'd6, 32'd42, 33);
    run_op("mulh_m1", T_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 33);
    @(negedge clk);
    run_op("mulhsu_m1", T_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
    @(negedge clk);
    run_op("mulhu_m1", T_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    @(negedge clk);
    run_op("div_m7_2", T_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    @(negedge clk);
    run_op("rem_m7_2", T_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    @(negedge clk);
    run_op("divu_100_7", T_DIVU, 32'd100, 32'd7, 32'd14, 33);
    run_op("remu_100_7", T_REMU, 32'd100, 32'd7, 32'd2, 33);
    @(negedge clk);
    run_op("mul_neg", T_MUL, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, 33);
    @(negedge clk);
    run_op("mulh_mixed", T_MULH, 32'h8000_0000, 32'd2, 32'hFFFF_FFFF, 33);
    @(negedge clk);

    // Corner cases resolve on the capture edge, including back-to-back.
    run_op("div_by_zero", T_DIV, 32'd1234, 32'd0, 32'hFFFF_FFFF, 0);
    run_op("remu_by_zero", T_REMU, 32'd5, 32'd0, 32'd5, 0);
    run_op("div_overflow", T_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
    run_op("rem_overflow", T_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0);
    @(negedge clk);

    // Flush at CALC cycle 10 abandons the op and keeps the old result.
    apply_stimulus(T_DIVU, 32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check_output("flush_busy_drop", {31'd0, busy}, 32'd0);
    expect_quiet("flush", 32'd0, 40);

    // Flush together with start while accepting drops the start.
    flush = 1'b1;
    apply_stimulus(T_MUL, 32'd2, 32'd3);
    flush = 1'b0;
    expect_quiet("flush_start", 32'd0, 5);

    // Illegal select is ignored.
    apply_stimulus(5'b00011, 32'd9, 32'd9);
    expect_quiet("illegal_sel", 32'd0, 5);

    // A start while busy is ignored; the first result comes through.
    apply_stimulus(T_MUL, 32'd3, 32'd5);
    repeat (5) @(negedge clk);
    start  = 1'b1;
    select = T_DIVU;
    data1  = 32'd100;
    data2  = 32'd7;
    @(negedge clk);
    start  = 1'b0;
    wait_done("start_while_busy", 32'd15, 33, 6);
    @(negedge clk);

    // Reset mid-CALC clears outputs without waiting for a clock edge.
    apply_stimulus(T_MULHU, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_output("async_reset_result", result, 32'd0);
    check_output("async_reset_busy", {31'd0, busy}, 32'd0);
    check_output("async_reset_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    run_op("after_reset", T_DIV, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 33);
    @(negedge clk);
    @(negedge clk);

    checking = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got timeout, expected completion");
    $fatal(1, "[TB] simulation time limit exceeded");
  end

endmodule

// File: doc/mdu_sequencer.md
# mdu_sequencer

Multi-cycle sequencer for the RV32IM M-extension operations (MUL, MULH, MULHU, MULHSU, DIV, DIVU, REM, REMU) in the EX stage. It accepts one operation at a time from the pipeline, runs a 32-step iterative shift-add multiply or restoring divide, and applies RISC-V sign and corner-case rules. It holds BUSY so the hazard unit can stall, then returns the 32-bit result with a one-cycle DONE pulse. It replaces the single-cycle M-extension paths in the ALU; the ALU keeps all RV32I operations.

## Interface
- XLEN, 32, operand/result width; only 32 is supported.
- CLK  in  1  pipeline clock; all state changes on its rising edge.
- RESET  in  1  asynchronous, active-high reset.
- START  in  1  request; sampled on a rising edge while the sequencer is accepting.
- SELECT  in  5  ALU select code: 5'b01001 MUL, 01010 MULH, 01011 MULHU, 01100 MULHSU, 01101 DIV, 01110 DIVU, 01111 REM, 10000 REMU.
- DATA1  in  32  rs1 operand (dividend / multiplicand).
- DATA2  in  32  rs2 operand (divisor / multiplier).
- FLUSH  in  1  abort the in-flight operation (branch mispredict / trap).
- RESULT  out  32  registered result; holds its value until the next completion.
- BUSY  out  1  operation in progress; the pipeline stalls EX while this is high.
- DONE  out  1  one-cycle pulse; RESULT is valid in the same cycle.

## Operation
- States:
  - IDLE: accepting.
  - CALC: 32 iterations, 5-bit counter.
  - FIX: sign correction and high/low word select.
  - DONE_S: RESULT valid, DONE=1, accepting.
- Accepting means state is IDLE or DONE_S. In either state, START with a legal SELECT captures SELECT, DATA1 and DATA2; later input changes have no effect.
- START with an illegal SELECT is ignored: no state change, no DONE.
- START while BUSY is ignored.
- Multiply:
  - Take operand magnitudes per signedness: MULH signed×signed, MULHSU signed×unsigned, MULHU and MUL unsigned.
  - Shift-add into a 64-bit accumulator, one multiplier bit per CALC cycle.
  - FIX negates the product when the operand signs differ and the operation is signed.
  - MUL returns bits [31:0]; the MULH family returns bits [63:32].
- Divide:
  - Restoring divide on magnitudes, one quotient bit per CALC cycle.
  - FIX negates the quotient if the signs differ and the remainder if the dividend is negative (signed operations only).
- Corner cases are resolved at capture: IDLE or DONE_S goes straight to DONE_S with no CALC.
  - Divide by zero: DIV and DIVU return 32'hFFFFFFFF; REM and REMU return DATA1.
  - Signed overflow (DATA1 = 32'h80000000, DATA2 = 32'hFFFFFFFF): DIV returns 32'h80000000; REM returns 0.
- DONE_S lasts one cycle, then goes to IDLE, or to CALC / DONE_S on a new START.
- FLUSH is asserted in CALC or FIX: next edge goes to IDLE, no DONE, RESULT unchanged. FLUSH together with START in an accepting state: FLUSH wins and START is dropped.
- RESET at any time: immediately state=IDLE, RESULT=0, BUSY=0, DONE=0, counter=0.

## Timing
- Reset values: RESULT 32'h0, BUSY 0, DONE 0.
- START sampled at edge k, normal path:
  - CALC from k to k+32.
  - FIX from k+32 to k+33.
  - DONE=1 and RESULT valid from k+33 to k+34.
  - Latency is 33 cycles.
- BUSY is high exactly while the state is CALC or FIX (32+1 cycles). BUSY is low in DONE_S, so back-to-back issue loses no cycle.
- Corner-case path: DONE=1 in the cycle after edge k (latency 1); BUSY never rises.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package mdu_pkg holds:
  - The SELECT code localparams, shared with the ALU decoder.
  - The state enum {IDLE, CALC, FIX, DONE_S}.
  - XLEN.
- One sub-module, mdu_step, holds the combinational single iteration (conditional add for multiply, trial subtract for divide) over the 64-bit accumulator.
- The FSM, counter and sign bookkeeping stay in mdu_sequencer.

## Test plan
- MUL 7×6, then MULH 32'hFFFFFFFF×32'hFFFFFFFF -> RESULT 42 with DONE exactly 33 cycles after START, then 0; BUSY high for 33 cycles each.
- MULHSU 32'hFFFFFFFF×32'hFFFFFFFF -> 32'hFFFFFFFF; MULHU of the same operands -> 32'hFFFFFFFE.
- DIV -7/2 -> 32'hFFFFFFFD; REM -7/2 -> 32'hFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIV x/0, REMU 5/0, and DIV 32'h80000000/32'hFFFFFFFF -> 32'hFFFFFFFF, 5 and 32'h80000000 respectively, each with DONE one cycle after START and BUSY never high.
- Interruptions:
  - FLUSH at CALC cycle 10 -> no DONE, BUSY drops next edge, RESULT keeps its previous value.
  - RESET asserted mid-CALC -> outputs go to 0 asynchronously.
  - START during BUSY -> ignored.
- Back-to-back: START asserted in the DONE_S cycle -> second DONE arrives 33 cycles later with the correct result; inputs changed after capture do not affect either result.
